core_ctrl: RTL and testbench
============================

CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 Parameter col, default 8: PE columns, which is also the number of kernel rows per kij.
REQ-002 Parameter row, default 8: PE rows.
REQ-003 Parameter len_nij, default 36: activation words per tile.
REQ-004 Parameter len_kij, default 9: kernel positions per run.
REQ-005 Parameter gap, default 10: idle cycles between kernel load and activation load.
REQ-006 Parameter w_base, default 11'h400: XMEM base address of kernel words.
REQ-007 clk  input  1  single clock; all logic samples on the rising edge.
REQ-008 reset  input  1  synchronous, active-high.
REQ-009 start  input  1  run request; sampled only in IDLE.
REQ-010 ofifo_valid  input  1  OFIFO holds readable data.
REQ-011 inst  output  34  registered core instruction word. Bit map: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-012 busy  output  1  high in any state except IDLE.
REQ-013 done  output  1  one-cycle pulse on run completion.
REQ-014 kij  output  4  current kernel index.

Function
REQ-015 The IDLE instruction word SHALL be 34'h1_800C_0000: both CEN and WEN bits high, all other bits 0.
REQ-016 The FSM SHALL have these states: IDLE, WLD, WLOAD, GAP, XLD, EXEC, FLUSH, DRAIN, NEXT.
REQ-017 All outputs SHALL be registered; the inst word for cycle n+1 is decided from state and counters at edge n.
REQ-018 IDLE with start=1 SHALL go to WLD with kij=0 and the cycle counter cnt=0; start=1 while busy SHALL be ignored.
REQ-019 WLD SHALL last col cycles: CEN_xmem=0, WEN_xmem=1, l0_wr=1, A_xmem=w_base+kij*col+cnt.
REQ-020 WLOAD SHALL last 2*col-1 cycles with l0_rd=1 and load=1.
REQ-021 GAP SHALL last gap cycles with the idle instruction word.
REQ-022 XLD SHALL last len_nij cycles: CEN_xmem=0, WEN_xmem=1, l0_wr=1, A_xmem=cnt.
REQ-023 EXEC SHALL last len_nij cycles with l0_rd=1 and execute=1.
REQ-024 FLUSH SHALL last row+col cycles with the idle word, so the array drains into the OFIFO.
REQ-025 DRAIN SHALL wait while ofifo_valid=0 and then issue exactly len_nij consecutive cycles of ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=kij*len_nij+cnt.
REQ-026 A drop of ofifo_valid during a drain burst SHALL NOT pause the burst; the OFIFO depth of at least len_nij guarantees the data.
REQ-027 NEXT SHALL take one cycle: if kij==len_kij-1, go to IDLE and pulse done; otherwise kij+1 and go to WLD.
REQ-028 cnt SHALL reset to 0 on every state transition; each state exits when cnt==length-1.
REQ-029 acc, ififo_wr and ififo_rd SHALL stay 0 in every state.
REQ-030 Every address field SHALL be 11 bits wide and truncate modulo 2048; with the default parameters the highest pmem address is 323 and the highest weight address is 0x447.

Reset
REQ-031 reset=1 at any edge SHALL force on the next cycle: state IDLE, inst=34'h1_800C_0000, busy=0, done=0, kij=0, cnt=0.
REQ-032 reset SHALL take priority over start and over any in-flight state, with no partial write completion.
REQ-033 reset released with start=1 in the same cycle SHALL leave the FSM in IDLE; start is acted on from the following edge.

Verification
REQ-034 Pulse start with defaults and ofifo_valid tied 1 -> busy for 9*(8+15+10+36+36+16+36+1)=1422 cycles, then one done pulse and return to IDLE.
REQ-035 kij=2 WLD -> A_xmem sequence 0x410..0x417 with l0_wr=1 and WEN_xmem=1 on each of the 8 cycles.
REQ-036 Hold ofifo_valid=0 for 20 cycles in DRAIN -> inst stays 34'h1_800C_0000; after valid rises, 36 read cycles with A_pmem=kij*36..kij*36+35.
REQ-037 Assert reset in the 5th EXEC cycle of kij=4 -> next cycle inst=34'h1_800C_0000 and busy=0; a new start restarts at kij=0, A_xmem=0x400.
REQ-038 Pulse start again during DRAIN -> no effect: kij sequence continues unchanged and exactly one done pulse is produced.
REQ-039 Scoreboard every cycle -> the acc, ififo_wr and ififo_rd bits stay 0 throughout, and load and execute are never high in the same cycle.

Source files
------------

// File: rtl/core_ctrl_if.sv
// core_ctrl_if: control/status bundle between the core controller and its
// surroundings.
//   start        run request into the controller
//   ofifo_valid  OFIFO has readable data
//   inst[33:0]   registered core instruction word
//   busy         controller is not idle
//   done         one-cycle pulse at the end of a run
//   kij[3:0]     current kernel index
// The master modport is the controller side; the slave modport is the side
// that drives start/ofifo_valid and consumes the instruction stream.
interface core_ctrl_if;
  logic        start;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij;

  modport master (
    input  start,
    input  ofifo_valid,
    output inst,
    output busy,
    output done,
    output kij
  );

  modport slave (
    output start,
    output ofifo_valid,
    input  inst,
    input  busy,
    input  done,
    input  kij
  );
endinterface

// File: rtl/core_ctrl.sv
// core_ctrl: sequences one convolution run over len_kij kernel positions.
// Per kernel position: load col kernel words from XMEM into L0, push them into
// the PE array, wait gap cycles, load len_nij activations into L0, execute,
// flush the array into the OFIFO, then drain len_nij results into PMEM.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   bus.start    run request, sampled only while idle
//   bus.ofifo_valid  OFIFO has data; starts the drain burst
//   bus.inst     registered 34-bit instruction word
//   bus.busy     high whenever the controller is not idle
//   bus.done     one-cycle pulse after the last kernel position
//   bus.kij      current kernel index
module core_ctrl #(
  parameter int unsigned col     = 8,
  parameter int unsigned row     = 8,
  parameter int unsigned len_nij = 36,
  parameter int unsigned len_kij = 9,
  parameter int unsigned gap     = 10,
  parameter logic [10:0] w_base  = 11'h400
) (
  input  logic              clk,
  input  logic              reset,
  core_ctrl_if.master       bus
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned KIJ_W  = 4;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned INST_W = 34;

  // Instruction word bit positions
  localparam int unsigned B_CEN_P  = 32;
  localparam int unsigned B_WEN_P  = 31;
  localparam int unsigned B_A_P    = 20;
  localparam int unsigned B_CEN_X  = 19;
  localparam int unsigned B_A_X    = 7;
  localparam int unsigned B_OF_RD  = 6;
  localparam int unsigned B_L0_RD  = 3;
  localparam int unsigned B_L0_WR  = 2;
  localparam int unsigned B_EXEC   = 1;
  localparam int unsigned B_LOAD   = 0;

  // Both memories disabled and write-protected, everything else quiet
  localparam logic [INST_W-1:0] IDLE_WORD = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_WLD, S_WLOAD, S_GAP, S_XLD, S_EXEC, S_FLUSH, S_DRAIN, S_NEXT
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [KIJ_W-1:0]    kij_q, kij_d;
  logic                rd_q, rd_d;      // current DRAIN cycle is a read cycle
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    len_c;
  logic                last_c;
  logic [ADDR_W-1:0]   w_addr_c;
  logic [ADDR_W-1:0]   p_addr_c;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kij_q   <= '0;
      rd_q    <= 1'b0;
      inst_q  <= IDLE_WORD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      rd_q    <= rd_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Dwell length of the current state
  always_comb begin
    len_c = CNT_W'(1);
    case (state_q)
      S_WLD:   len_c = CNT_W'(col);
      S_WLOAD: len_c = CNT_W'(2 * col - 1);
      S_GAP:   len_c = CNT_W'(gap);
      S_XLD:   len_c = CNT_W'(len_nij);
      S_EXEC:  len_c = CNT_W'(len_nij);
      S_FLUSH: len_c = CNT_W'(row + col);
      S_DRAIN: len_c = CNT_W'(len_nij);
      default: len_c = CNT_W'(1);
    endcase
  end

  assign last_c = (cnt_q == len_c - CNT_W'(1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    kij_d   = kij_q;
    rd_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d = S_WLD;
          kij_d   = '0;
        end
      end
      S_WLD:   if (last_c) begin state_d = S_WLOAD; cnt_d = '0; end
      S_WLOAD: if (last_c) begin state_d = S_GAP;   cnt_d = '0; end
      S_GAP:   if (last_c) begin state_d = S_XLD;   cnt_d = '0; end
      S_XLD:   if (last_c) begin state_d = S_EXEC;  cnt_d = '0; end
      S_EXEC:  if (last_c) begin state_d = S_FLUSH; cnt_d = '0; end
      S_FLUSH: begin
        if (last_c) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          rd_d    = bus.ofifo_valid;
        end
      end
      S_DRAIN: begin
        // Once the burst has begun it runs to completion regardless of valid
        if (rd_q) begin
          if (last_c) begin
            state_d = S_NEXT;
            cnt_d   = '0;
          end else begin
            rd_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q;
          rd_d  = bus.ofifo_valid;
        end
      end
      S_NEXT: begin
        cnt_d = '0;
        if (kij_q == KIJ_W'(len_kij - 1)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WLD;
          kij_d   = kij_q + KIJ_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign w_addr_c = ADDR_W'(32'(w_base) + 32'(kij_d) * col + 32'(cnt_d));
  assign p_addr_c = ADDR_W'(32'(kij_d) * len_nij + 32'(cnt_d));

  // Output decode of the upcoming cycle, registered at the same edge
  always_comb begin
    inst_d = IDLE_WORD;
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_NEXT) && (state_d == S_IDLE);
    case (state_d)
      S_WLD: begin
        inst_d[B_CEN_X]            = 1'b0;
        inst_d[B_A_X +: ADDR_W]    = w_addr_c;
        inst_d[B_L0_WR]            = 1'b1;
      end
      S_WLOAD: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_LOAD]  = 1'b1;
      end
      S_XLD: begin
        inst_d[B_CEN_X]            = 1'b0;
        inst_d[B_A_X +: ADDR_W]    = ADDR_W'(cnt_d);
        inst_d[B_L0_WR]            = 1'b1;
      end
      S_EXEC: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_EXEC]  = 1'b1;
      end
      S_DRAIN: begin
        if (rd_d) begin
          inst_d[B_OF_RD]         = 1'b1;
          inst_d[B_CEN_P]         = 1'b0;
          inst_d[B_WEN_P]         = 1'b0;
          inst_d[B_A_P +: ADDR_W] = p_addr_c;
        end
      end
      default: inst_d = IDLE_WORD;
    endcase
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.kij  = kij_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: self-checking bench for core_ctrl.
// Fixed-vector table over a full default run, hand sequences for the drain
// stall and mid-run reset, and randomized ofifo_valid/start checked against a
// trace built from the per-phase rules.
module tb_core_ctrl;
  localparam int unsigned COL  = 8;
  localparam int unsigned ROW  = 8;
  localparam int unsigned NIJ  = 36;
  localparam int unsigned NKIJ = 9;
  localparam int unsigned GAP  = 10;
  localparam int unsigned PER  = COL + (2 * COL - 1) + GAP + NIJ + NIJ + (ROW + COL) + NIJ + 1;
  localparam int unsigned MAXC = 4096;
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic clk = 1'b0;
  logic reset;
  core_ctrl_if bus ();

  core_ctrl #(.col(COL), .row(ROW), .len_nij(NIJ), .len_kij(NKIJ), .gap(GAP), .w_base(11'h400))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          cyc;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij;
    logic        kchk;
  } vec_t;

  typedef struct {
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij;
  } exp_t;

  vec_t tbl[$];
  exp_t tr[$];
  logic v[MAXC];

  function automatic logic [33:0] w_xmem(input logic [10:0] a);
    logic [33:0] w;
    w = IDLE_W; w[19] = 1'b0; w[17:7] = a; w[2] = 1'b1;
    return w;
  endfunction

  function automatic logic [33:0] w_load();
    logic [33:0] w;
    w = IDLE_W; w[3] = 1'b1; w[0] = 1'b1;
    return w;
  endfunction

  function automatic logic [33:0] w_exec();
    logic [33:0] w;
    w = IDLE_W; w[3] = 1'b1; w[1] = 1'b1;
    return w;
  endfunction

  function automatic logic [33:0] w_drain(input logic [10:0] a);
    logic [33:0] w;
    w = IDLE_W; w[32] = 1'b0; w[31] = 1'b0; w[30:20] = a; w[6] = 1'b1;
    return w;
  endfunction

  function automatic vec_t mkv(input int c, input logic [33:0] i, input logic b,
                               input logic d, input int k, input logic kc);
    vec_t r;
    r.cyc = c; r.inst = i; r.busy = b; r.done = d; r.kij = 4'(k); r.kchk = kc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bits that must never be set, and load/execute never together
  task automatic inv(input int t);
    n_tests++;
    if ({bus.inst[33], bus.inst[5], bus.inst[4]} !== 3'b000 || (bus.inst[1] && bus.inst[0])) begin
      n_fail++;
      $display("FAIL invariant cycle %0d: inst %h", t, bus.inst);
    end
  endtask

  task automatic push(input logic [33:0] i, input logic b, input logic d, input int k);
    exp_t e;
    e.inst = i; e.busy = b; e.done = d; e.kij = 4'(k);
    tr.push_back(e);
  endtask

  // Expected cycle-by-cycle trace for one run given the valid sequence v[]
  task automatic build_trace();
    tr.delete();
    for (int k = 0; k < int'(NKIJ); k++) begin
      for (int c = 0; c < int'(COL); c++)       push(w_xmem(11'(1024 + k * int'(COL) + c)), 1'b1, 1'b0, k);
      for (int c = 0; c < int'(2 * COL - 1); c++) push(w_load(), 1'b1, 1'b0, k);
      for (int c = 0; c < int'(GAP); c++)       push(IDLE_W, 1'b1, 1'b0, k);
      for (int c = 0; c < int'(NIJ); c++)       push(w_xmem(11'(c)), 1'b1, 1'b0, k);
      for (int c = 0; c < int'(NIJ); c++)       push(w_exec(), 1'b1, 1'b0, k);
      for (int c = 0; c < int'(ROW + COL); c++) push(IDLE_W, 1'b1, 1'b0, k);
      // Cycle t reads only if valid was seen at the edge opening it
      while (tr.size() < MAXC - 1 && !v[tr.size() - 1]) push(IDLE_W, 1'b1, 1'b0, k);
      for (int c = 0; c < int'(NIJ); c++)       push(w_drain(11'(k * int'(NIJ) + c)), 1'b1, 1'b0, k);
      push(IDLE_W, 1'b1, 1'b0, k);
    end
    push(IDLE_W, 1'b0, 1'b1, 0);
    push(IDLE_W, 1'b0, 1'b0, 0);
  endtask

  task automatic run_random(input int p_valid);
    int n;
    for (int i = 0; i < int'(MAXC); i++) v[i] = ($urandom_range(0, 3) < p_valid);
    build_trace();
    n = tr.size();
    chk("model trace bound", 34'(n < int'(MAXC) - 2), 34'(1));
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < n; t++) begin
      bus.ofifo_valid = v[t];
      bus.start = (t < n - 3) && ($urandom_range(0, 15) == 0);
      @(negedge clk);
      inv(t);
      chk($sformatf("rnd%0d c%0d inst", p_valid, t), bus.inst, tr[t].inst);
      chk($sformatf("rnd%0d c%0d busy", p_valid, t), 34'(bus.busy), 34'(tr[t].busy));
      chk($sformatf("rnd%0d c%0d done", p_valid, t), 34'(bus.done), 34'(tr[t].done));
      if (tr[t].busy) chk($sformatf("rnd%0d c%0d kij", p_valid, t), 34'(bus.kij), 34'(tr[t].kij));
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int ti;
    int busy_cnt;
    int done_cnt;

    // Reset, with start held high across it
    reset = 1'b1; bus.start = 1'b1; bus.ofifo_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset inst", bus.inst, IDLE_W);
    chk("reset busy", 34'(bus.busy), 34'(0));
    chk("reset done", 34'(bus.done), 34'(0));
    chk("reset kij", 34'(bus.kij), 34'(0));
    @(posedge clk); #1;
    reset = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle after reset+start", 34'(bus.busy), 34'(0));
    chk("idle inst after reset+start", bus.inst, IDLE_W);

    // Full run, valid tied high, with stray starts (one in DRAIN)
    tbl.push_back(mkv(0,   w_xmem(11'h400), 1, 0, 0, 1));
    tbl.push_back(mkv(7,   w_xmem(11'h407), 1, 0, 0, 1));
    tbl.push_back(mkv(8,   w_load(),        1, 0, 0, 1));
    tbl.push_back(mkv(22,  w_load(),        1, 0, 0, 1));
    tbl.push_back(mkv(23,  IDLE_W,          1, 0, 0, 1));
    tbl.push_back(mkv(32,  IDLE_W,          1, 0, 0, 1));
    tbl.push_back(mkv(33,  w_xmem(11'd0),   1, 0, 0, 1));
    tbl.push_back(mkv(68,  w_xmem(11'd35),  1, 0, 0, 1));
    tbl.push_back(mkv(69,  w_exec(),        1, 0, 0, 1));
    tbl.push_back(mkv(104, w_exec(),        1, 0, 0, 1));
    tbl.push_back(mkv(105, IDLE_W,          1, 0, 0, 1));
    tbl.push_back(mkv(120, IDLE_W,          1, 0, 0, 1));
    tbl.push_back(mkv(121, w_drain(11'd0),  1, 0, 0, 1));
    tbl.push_back(mkv(156, w_drain(11'd35), 1, 0, 0, 1));
    tbl.push_back(mkv(157, IDLE_W,          1, 0, 0, 1));
    tbl.push_back(mkv(158, w_xmem(11'h408), 1, 0, 1, 1));
    tbl.push_back(mkv(316, w_xmem(11'h410), 1, 0, 2, 1));
    tbl.push_back(mkv(323, w_xmem(11'h417), 1, 0, 2, 1));
    tbl.push_back(mkv(437, w_drain(11'd72), 1, 0, 2, 1));
    tbl.push_back(mkv(474, w_xmem(11'h418), 1, 0, 3, 1));
    tbl.push_back(mkv(1271, w_xmem(11'h447), 1, 0, 8, 1));
    tbl.push_back(mkv(1420, w_drain(11'd323), 1, 0, 8, 1));
    tbl.push_back(mkv(1421, IDLE_W,         1, 0, 8, 1));
    tbl.push_back(mkv(1422, IDLE_W,         0, 1, 0, 0));
    tbl.push_back(mkv(1423, IDLE_W,         0, 0, 0, 0));

    bus.ofifo_valid = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    ti = 0; busy_cnt = 0; done_cnt = 0;
    for (int t = 0; t < 1430; t++) begin
      bus.start = (t == 200) || (t == 2 * int'(PER) + 130);
      @(negedge clk);
      inv(t);
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
      while (ti < tbl.size() && tbl[ti].cyc == t) begin
        chk($sformatf("tbl c%0d inst", t), bus.inst, tbl[ti].inst);
        chk($sformatf("tbl c%0d busy", t), 34'(bus.busy), 34'(tbl[ti].busy));
        chk($sformatf("tbl c%0d done", t), 34'(bus.done), 34'(tbl[ti].done));
        if (tbl[ti].kchk) chk($sformatf("tbl c%0d kij", t), 34'(bus.kij), 34'(tbl[ti].kij));
        ti++;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("run busy cycles", 34'(busy_cnt), 34'(1422));
    chk("run done pulses", 34'(done_cnt), 34'(1));

    // Drain stall: valid low across the FLUSH->DRAIN boundary for 21 DRAIN cycles
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int t = 0; t <= 180; t++) begin
      bus.ofifo_valid = !(t >= 100 && t <= 140);
      @(negedge clk);
      inv(t);
      if (t == 121) chk("stall first drain cycle", bus.inst, IDLE_W);
      if (t == 141) chk("stall last idle cycle", bus.inst, IDLE_W);
      if (t == 141) chk("stall busy", 34'(bus.busy), 34'(1));
      if (t == 142) chk("stall first read", bus.inst, w_drain(11'd0));
      if (t == 177) chk("stall last read", bus.inst, w_drain(11'd35));
      if (t == 178) chk("stall next", bus.inst, IDLE_W);
      if (t == 179) chk("stall kij1 wld", bus.inst, w_xmem(11'h408));
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset in the 5th EXEC cycle of kij=4, then restart
    bus.ofifo_valid = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int t = 0; t <= 709; t++) begin
      reset     = (t == 705);
      bus.start = (t == 705) || (t == 708);
      @(negedge clk);
      inv(t);
      if (t == 705) begin
        chk("pre-reset exec", bus.inst, w_exec());
        chk("pre-reset kij", 34'(bus.kij), 34'(4));
      end
      if (t == 706) begin
        chk("mid-reset inst", bus.inst, IDLE_W);
        chk("mid-reset busy", 34'(bus.busy), 34'(0));
        chk("mid-reset kij", 34'(bus.kij), 34'(0));
        chk("mid-reset done", 34'(bus.done), 34'(0));
      end
      if (t == 707) chk("post-reset idle", 34'(bus.busy), 34'(0));
      if (t == 709) begin
        chk("restart inst", bus.inst, w_xmem(11'h400));
        chk("restart kij", 34'(bus.kij), 34'(0));
        chk("restart busy", 34'(bus.busy), 34'(1));
      end
      @(posedge clk); #1;
    end
    reset = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Randomized valid and stray starts against the trace model
    run_random(1);
    run_random(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
